// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, big-endian word frame over a valid/ready byte port, writes it to RAM, then releases the CPU.
// Define BOOT_LOADER_CSUM_EN to expect and verify a trailing 8-bit additive checksum byte.
module boot_loader #(
  parameter int MEM_DEPTH = 2048,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef BOOT_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_t;

`ifdef BOOT_LOADER_CSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_RUN;
`endif

  localparam logic [16:0]     DEPTH_LIM = 17'(MEM_DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE   = 1;

  state_t            state, state_nxt;
  logic [15:0]       len_q;
  logic [15:0]       len_n;
  logic [ADDR_W:0]   idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic              accept;
  logic              word_last;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  assign accept    = in_valid && in_ready && !restart;
  assign len_n     = {len_q[15:8], in_data};
  // idx carries one extra bit so a full MEM_DEPTH frame compares cleanly
  assign word_last = (16'(idx) + 16'd1) == len_q;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_LEN_HI: in_ready = 1'b1;
      S_LEN_LO: in_ready = 1'b1;
      S_DATA:   in_ready = 1'b1;
`ifdef BOOT_LOADER_CSUM_EN
      S_CSUM:   in_ready = 1'b1;
`endif
      default:  in_ready = 1'b0;
    endcase

    if (restart) begin
      state_nxt = S_LEN_HI;
    end else if (accept) begin
      case (state)
        S_LEN_HI: state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if ({1'b0, len_n} > DEPTH_LIM) state_nxt = S_ERR;
          else if (len_n == 16'd0)        state_nxt = S_AFTER_DATA;
          else                            state_nxt = S_DATA;
        end
        S_DATA: begin
          if (byte_cnt == 2'd3 && word_last) state_nxt = S_AFTER_DATA;
        end
`ifdef BOOT_LOADER_CSUM_EN
        S_CSUM: state_nxt = (in_data == csum_q) ? S_RUN : S_ERR;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_LEN_HI;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_reset <= (state_nxt != S_RUN);
      done      <= (state_nxt == S_RUN);
      error     <= (state_nxt == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      idx       <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef BOOT_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        idx      <= '0;
        byte_cnt <= '0;
`ifdef BOOT_LOADER_CSUM_EN
        csum_q   <= '0;
`endif
      end else if (accept) begin
        case (state)
          S_LEN_HI: len_q[15:8] <= in_data;
          S_LEN_LO: begin
            len_q[7:0] <= in_data;
            idx        <= '0;
            byte_cnt   <= '0;
`ifdef BOOT_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
          end
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], in_data};
`ifdef BOOT_LOADER_CSUM_EN
            csum_q   <= csum_q + in_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= idx[ADDR_W-1:0];
              mem_wdata <= {asm_q, in_data};
              idx       <= idx + IDX_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a frame-level model queues expected RAM writes and final status; a negedge monitor checks every write.
module tb_boot_loader;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          reset, restart, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_reset, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  always #5 clk = ~clk;

  boot_loader #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  int            total = 0;
  int            bad   = 0;
  int            n_we  = 0;
  int            n0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [31:0]   fw[$];
  logic [AW-1:0] ea;
  logic [31:0]   ed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicts.
  always @(negedge clk) begin
    if (mem_we) begin
      n_we++;
      chk("we_expected", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", mem_wdata, ed);
      end
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
  end

  function automatic logic [7:0] model_csum();
    logic [7:0] s = 8'd0;
    foreach (fw[i]) s += fw[i][31:24] + fw[i][23:16] + fw[i][15:8] + fw[i][7:0];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit hs;
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    do begin
      hs = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 50);
    if (!hs) chk("handshake_timeout", 32'(hs), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic check_end(input bit ok, input string tag);
    @(negedge clk); #1;
    chk({tag, "_done"},      32'(done),      32'(ok));
    chk({tag, "_error"},     32'(error),     32'(!ok));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Full frame from fw[]; bad_csum offsets the checksum byte when the checksum is enabled.
  task automatic load_frame(input int len, input bit gaps, input int bad_csum, input string tag);
    logic [15:0] l16;
    bit          ok;
    l16 = 16'(len);
    ok  = (len <= DEPTH) && (bad_csum == 0);
    if (len <= DEPTH)
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(AW'(i));
        exp_data.push_back(fw[i]);
      end
    send_byte(l16[15:8], gaps);
    send_byte(l16[7:0], gaps);
    if (len <= DEPTH) begin
      for (int i = 0; i < len; i++) send_word(fw[i], gaps);
`ifdef BOOT_LOADER_CSUM_EN
      send_byte(model_csum() + 8'(bad_csum), gaps);
`endif
    end
    in_valid = 1'b0;
    check_end(ok, tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_error",     32'(error),     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic two-word frame, streamed back to back
    fw = {32'h20020055, 32'h00421020};
    chk("t1_csum_model", 32'(model_csum()), 32'h0000_00E9);
    load_frame(2, 1'b0, 0, "t1");
    chk("t1_last_addr", 32'(last_addr), 32'd1);
    chk("t1_last_data", last_data, 32'h00421020);

`ifdef BOOT_LOADER_CSUM_EN
    // Checksum 0xEA instead of 0xE9
    pulse_restart();
    load_frame(2, 1'b0, 1, "t2");
    in_valid = 1'b1; in_data = 8'h00;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
    chk("t2_hold_error",    32'(error),    32'd1);
`endif

    // Length 0x0801 exceeds the RAM
    pulse_restart();
    fw.delete();
    load_frame(2049, 1'b0, 0, "t3");
    in_valid = 1'b1; in_data = 8'h12;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
    chk("t3_hold_error",    32'(error),    32'd1);

    // Three words with idle gaps
    pulse_restart();
    fw = {32'h11223344, 32'hDEADBEEF, 32'h0000FFFF};
    n0 = n_we;
    load_frame(3, 1'b1, 0, "t4");
    chk("t4_we_pulses", 32'(n_we - n0), 32'd3);
    chk("t4_last_data", last_data, 32'h0000FFFF);

    // Restart after six data bytes, coincident with a handshake
    pulse_restart();
    exp_addr.push_back(AW'(0));
    exp_data.push_back(32'h20020055);
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_word(32'h20020055, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h42, 1'b0);
    in_valid = 1'b1; in_data = 8'h10; restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0;
    chk("t5_rs_in_ready",  32'(in_ready),  32'd1);
    chk("t5_rs_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t5_rs_done",      32'(done),      32'd0);
    @(negedge clk); #1;
    chk("t5_rs_no_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    fw = {32'hAABBCCDD};
    chk("t5_csum_model", 32'(model_csum()), 32'h0000_000E);
    n0 = n_we;
    load_frame(1, 1'b0, 0, "t5");
    chk("t5_we_pulses", 32'(n_we - n0), 32'd1);
    chk("t5_last_addr", 32'(last_addr), 32'd0);
    chk("t5_last_data", last_data, 32'hAABBCCDD);

    // Empty frame
    pulse_restart();
    fw.delete();
    load_frame(0, 1'b0, 0, "t6");

    // Async reset in the cycle the first word's write strobe is up
    pulse_restart();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_word(32'h20020055, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t7_in_ready",  32'(in_ready),  32'd1);
    chk("t7_mem_we",    32'(mem_we),    32'd0);
    chk("t7_mem_addr",  32'(mem_addr),  32'd0);
    chk("t7_mem_wdata", mem_wdata,      32'd0);
    chk("t7_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t7_done",      32'(done),      32'd0);
    chk("t7_error",     32'(error),     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    fw = {32'hCAFEF00D, 32'h12345678};
    load_frame(2, 1'b1, 0, "t7");

    // Largest legal frame fills the whole RAM
    pulse_restart();
    fw.delete();
    for (int i = 0; i < DEPTH; i++) fw.push_back(32'(i) * 32'h01000193 ^ 32'h5A5A0000);
    load_frame(DEPTH, 1'b0, 0, "t8");
    chk("t8_last_addr", 32'(last_addr), 32'd2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
